// File: rtl/sqrt_fp_iter.sv
// Iterative floating-point sqrt / inverse sqrt, one result bit per cycle.
// Define SQRT_INV_EN to build the 1/q divider; without it inverse requests return NaN.
module sqrt_fp_iter #(
    parameter int unsigned FW = 8,
    parameter int unsigned EW = 8,
    parameter int unsigned OW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          doSqrt_i,
    input  logic          doInvSqrt_i,
    input  logic          s_i,
    input  logic [FW-1:0] f_i,
    input  logic [EW-1:0] e_i,
    input  logic          isZ_i,
    input  logic          isInf_i,
    input  logic          isSNAN_i,
    input  logic          isQNAN_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic          s_o,
    output logic [OW-1:0] f_o,
    output logic [EW-1:0] e_o,
    output logic          isNaN_o,
    output logic          isInf_o,
    output logic          isZero_o,
    output logic          isOverflow_o,
    output logic          isUnderflow_o,
    output logic          isToRound_o
);
    localparam int unsigned RW  = OW + 3;
    localparam int unsigned SH  = 2 * OW - FW - 1;
    localparam int unsigned CW  = $clog2(OW + 2);
    localparam int unsigned LZW = $clog2(FW + 1);
    localparam int unsigned XW  = EW + 2;
    localparam logic signed [XW-1:0] EMax = XW'(2 ** (EW - 1) - 1);
    localparam logic signed [XW-1:0] EMin = -(XW'(2 ** (EW - 1)));

    typedef enum logic [2:0] {StIdle, StPrep, StSqrt, StDiv, StDone} state_e;

    state_e          state_q, state_d;
    logic            inv_q, inv_d, sgn_q, sgn_d, isz_q, isz_d, isinf_q, isinf_d;
    logic            nanin_q, nanin_d, sticky_q, sticky_d;
    logic            rnan_q, rnan_d, rinf_q, rinf_d, rzero_q, rzero_d;
    logic [FW-1:0]   frac_q, frac_d;
    logic [XW-1:0]   exp_q, exp_d;
    logic [2*OW-1:0] rad_q, rad_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [OW-1:0]   root_q, root_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef SQRT_INV_EN
    logic [OW:0]     quo_q, quo_d;
    logic            dv_ge;
    logic [RW-1:0]   dv_rem;
`endif

    logic            valid_q, valid_d, nan_o_q, nan_o_d, inf_o_q, inf_o_d, zero_o_q, zero_o_d;
    logic            ovf_q, ovf_d, unf_q, unf_d, rnd_q, rnd_d;
    logic [OW-1:0]   fo_q, fo_d;
    logic [EW-1:0]   eo_q, eo_d;

    logic [LZW-1:0]  lz;
    logic [FW-1:0]   fn;
    logic [XW-1:0]   e_n, e_adj;
    logic [FW:0]     xi;
    logic            opz, opnan;
    logic [RW-1:0]   sq_rem_sh, sq_trial, sq_rem;
    logic            sq_ge;
    logic signed [XW-1:0] es, res_exp;
    logic [OW-1:0]   res_frac;
    logic            res_ovf, res_unf;

    always_comb begin
        lz = LZW'(FW);
        for (int i = 0; i < int'(FW); i++) begin
            if (frac_q[i]) lz = LZW'(int'(FW) - 1 - i);
        end
        fn    = frac_q << lz;
        e_n   = exp_q - {{(XW - LZW){1'b0}}, lz};
        // Odd exponent: fold one factor of two into the radicand so e stays even.
        xi    = e_n[0] ? {fn, 1'b0} : {1'b0, fn};
        e_adj = e_n - XW'(e_n[0]);
        opz   = isz_q | (frac_q == '0 && !isinf_q && !nanin_q);
        opnan = nanin_q | (sgn_q & ~opz);
`ifndef SQRT_INV_EN
        opnan = opnan | inv_q;
`endif
        sq_rem_sh = {rem_q[RW-3:0], rad_q[2*OW-1 -: 2]};
        sq_trial  = RW'({root_q, 2'b01});
        sq_ge     = sq_rem_sh >= sq_trial;
        sq_rem    = sq_ge ? sq_rem_sh - sq_trial : sq_rem_sh;
`ifdef SQRT_INV_EN
        dv_ge  = rem_q >= RW'(root_q);
        dv_rem = dv_ge ? rem_q - RW'(root_q) : rem_q;
`endif
    end

    always_comb begin
        state_d  = state_q;
        inv_d    = inv_q;
        sgn_d    = sgn_q;
        isz_d    = isz_q;
        isinf_d  = isinf_q;
        nanin_d  = nanin_q;
        frac_d   = frac_q;
        exp_d    = exp_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        rnan_d   = rnan_q;
        rinf_d   = rinf_q;
        rzero_d  = rzero_q;
`ifdef SQRT_INV_EN
        quo_d    = quo_q;
`endif
        case (state_q)
            StIdle: begin
                if (doSqrt_i || doInvSqrt_i) begin
                    state_d = StPrep;
                    inv_d   = doInvSqrt_i & ~doSqrt_i;
                    sgn_d   = s_i;
                    isz_d   = isZ_i;
                    isinf_d = isInf_i;
                    nanin_d = isSNAN_i | isQNAN_i;
                    frac_d  = f_i;
                    exp_d   = {{2{e_i[EW-1]}}, e_i};
                end
            end
            StPrep: begin
                rnan_d   = opnan;
                rinf_d   = ~opnan & (opz ? inv_q : (isinf_q & ~inv_q));
                rzero_d  = ~opnan & (opz ? ~inv_q : (isinf_q & inv_q));
                exp_d    = e_adj;
                rad_d    = {xi, {SH{1'b0}}};
                rem_d    = '0;
                root_d   = '0;
                cnt_d    = '0;
                sticky_d = 1'b0;
                state_d  = (opnan || opz || isinf_q) ? StDone : StSqrt;
            end
            StSqrt: begin
                rem_d  = sq_rem;
                root_d = {root_q[OW-2:0], sq_ge};
                rad_d  = rad_q << 2;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(OW - 1)) begin
                    sticky_d = sq_rem != '0;
                    cnt_d    = '0;
                    state_d  = StDone;
`ifdef SQRT_INV_EN
                    if (inv_q) begin
                        state_d = StDiv;
                        rem_d   = RW'(1) << (OW - 1);
                        quo_d   = '0;
                    end
`endif
                end
            end
`ifdef SQRT_INV_EN
            StDiv: begin
                rem_d = dv_rem << 1;
                quo_d = {quo_q[OW-1:0], dv_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(OW)) begin
                    sticky_d = sticky_q | (dv_rem != '0);
                    state_d  = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        es       = $signed(exp_q) >>> 1;
        res_frac = root_q;
        res_exp  = es;
`ifdef SQRT_INV_EN
        if (inv_q) begin
            // Quotient is in (0.5,1]; only exactly 1.0 keeps the top bit.
            if (quo_q[OW]) begin
                res_frac = quo_q[OW:1];
                res_exp  = -es;
            end else begin
                res_frac = quo_q[OW-1:0];
                res_exp  = -es - 1'sb1;
            end
        end
`endif
        res_ovf  = res_exp > EMax;
        res_unf  = res_exp < EMin;
        valid_d  = 1'b0;
        fo_d     = fo_q;
        eo_d     = eo_q;
        nan_o_d  = nan_o_q;
        inf_o_d  = inf_o_q;
        zero_o_d = zero_o_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        rnd_d    = rnd_q;
        if (state_q == StDone) begin
            valid_d  = 1'b1;
            fo_d     = '0;
            eo_d     = '0;
            nan_o_d  = rnan_q;
            inf_o_d  = rinf_q;
            zero_o_d = rzero_q;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            rnd_d    = 1'b0;
            if (!(rnan_q || rinf_q || rzero_q)) begin
                rnd_d = sticky_q;
                if (res_ovf) begin
                    inf_o_d = 1'b1;
                    ovf_d   = 1'b1;
                end else if (res_unf) begin
                    zero_o_d = 1'b1;
                    unf_d    = 1'b1;
                end else begin
                    fo_d = res_frac;
                    eo_d = res_exp[EW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            inv_q    <= 1'b0;
            sgn_q    <= 1'b0;
            isz_q    <= 1'b0;
            isinf_q  <= 1'b0;
            nanin_q  <= 1'b0;
            frac_q   <= '0;
            exp_q    <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            rnan_q   <= 1'b0;
            rinf_q   <= 1'b0;
            rzero_q  <= 1'b0;
`ifdef SQRT_INV_EN
            quo_q    <= '0;
`endif
            valid_q  <= 1'b0;
            fo_q     <= '0;
            eo_q     <= '0;
            nan_o_q  <= 1'b0;
            inf_o_q  <= 1'b0;
            zero_o_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rnd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            inv_q    <= inv_d;
            sgn_q    <= sgn_d;
            isz_q    <= isz_d;
            isinf_q  <= isinf_d;
            nanin_q  <= nanin_d;
            frac_q   <= frac_d;
            exp_q    <= exp_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            rnan_q   <= rnan_d;
            rinf_q   <= rinf_d;
            rzero_q  <= rzero_d;
`ifdef SQRT_INV_EN
            quo_q    <= quo_d;
`endif
            valid_q  <= valid_d;
            fo_q     <= fo_d;
            eo_q     <= eo_d;
            nan_o_q  <= nan_o_d;
            inf_o_q  <= inf_o_d;
            zero_o_q <= zero_o_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rnd_q    <= rnd_d;
        end
    end

    assign ready_o       = state_q == StIdle;
    assign valid_o       = valid_q;
    assign s_o           = 1'b0;
    assign f_o           = fo_q;
    assign e_o           = eo_q;
    assign isNaN_o       = nan_o_q;
    assign isInf_o       = inf_o_q;
    assign isZero_o      = zero_o_q;
    assign isOverflow_o  = ovf_q;
    assign isUnderflow_o = unf_q;
    assign isToRound_o   = rnd_q;

endmodule
